axi_xbar_rx_arbiter: RTL

//  Per-receiver (slave-side) arbiter of the AXI4 crossbar. Chooses one of SENDER_NUM senders

---
 rtl/axi_xbar_pkg.sv | 14 +
 rtl/axi_rr_picker.sv | 33 +++
 rtl/axi_xbar_rx_arbiter.sv | 138 +++++++++++++
 3 files changed

// File: rtl/axi_xbar_pkg.sv
// Shared types and defaults for the AXI4 crossbar arbiters.
package axi_xbar_pkg;

  // Per-receiver arbiter phases: waiting, address outstanding, data outstanding.
  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_ADDR = 2'd1,
    ARB_DATA = 2'd2
  } arb_state_e;

  // Default stall budget before a granted sender is forcibly released.
  localparam int unsigned ARB_TIMEOUT_DEF = 256;

endpackage

// File: rtl/axi_rr_picker.sv
// Combinational round-robin picker: first asserted request after rr_ptr, modulo SENDER_NUM.
// The request vector is doubled and shifted down by the start position, so a plain
// lowest-set-bit search covers the wrap-around without a second masked pass.
module axi_rr_picker #(
  parameter int unsigned SENDER_NUM = 8,
  parameter int unsigned IDX_W      = $clog2(SENDER_NUM)
) (
  input  logic [SENDER_NUM-1:0] req,
  input  logic [IDX_W-1:0]      rr_ptr,
  output logic [IDX_W-1:0]      win_idx,
  output logic                  win_vld
);

  logic [IDX_W-1:0]      start_c;
  logic [SENDER_NUM-1:0] rot_c;
  int                    off_c;
  int                    sum_c;

  // Rotate requests so the highest-priority sender lands at bit 0, then find the first one.
  always_comb begin
    start_c = (rr_ptr == IDX_W'(SENDER_NUM - 1)) ? '0 : rr_ptr + IDX_W'(1);
    rot_c   = SENDER_NUM'({req, req} >> start_c);
    win_vld = |req;
    off_c   = 0;
    for (int i = SENDER_NUM - 1; i >= 0; i--) begin
      if (rot_c[i]) off_c = i;
    end
    sum_c = int'(start_c) + off_c;
    if (sum_c >= int'(SENDER_NUM)) sum_c = sum_c - int'(SENDER_NUM);
    win_idx = IDX_W'(sum_c);
  end

endmodule

// File: rtl/axi_xbar_rx_arbiter.sv
// Per-receiver arbiter of the AXI4 crossbar: round-robin grant held for one whole burst.
// Optional stall watchdog enabled by defining AXI_ARB_TIMEOUT_EN.
module axi_xbar_rx_arbiter
  import axi_xbar_pkg::*;
#(
  parameter int unsigned SENDER_NUM = 8,
  parameter int unsigned TIMEOUT    = ARB_TIMEOUT_DEF,
  parameter int unsigned IDX_W      = $clog2(SENDER_NUM)
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  input  logic [SENDER_NUM-1:0] req,
  input  logic                  addr_hs,
  input  logic                  last_hs,
  output logic [SENDER_NUM-1:0] grant,
  output logic [IDX_W-1:0]      grant_idx,
  output logic                  busy,
  output logic                  timeout_err
);

  arb_state_e            state_q, state_d;
  logic [SENDER_NUM-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic                  busy_q, busy_d;
  logic                  release_c;
  logic                  forced_c;
  logic [IDX_W-1:0]      win_idx_c;
  logic                  win_vld_c;

  axi_rr_picker #(
    .SENDER_NUM (SENDER_NUM),
    .IDX_W      (IDX_W)
  ) u_picker (
    .req     (req),
    .rr_ptr  (rr_ptr_q),
    .win_idx (win_idx_c),
    .win_vld (win_vld_c)
  );

`ifdef AXI_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             tmo_q;

  // Stall counter: runs while a burst is outstanding, cleared by any handshake or release.
  always_comb begin
    stall_cnt_d = '0;
    forced_c    = 1'b0;
    if (state_q != ARB_IDLE && !addr_hs && !last_hs) begin
      if (stall_cnt_q == CNT_W'(TIMEOUT - 1)) begin
        forced_c = 1'b1;
      end else begin
        stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
    end
  end

  // Stall counter and one-cycle timeout pulse registers.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      stall_cnt_q <= '0;
      tmo_q       <= 1'b0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      tmo_q       <= forced_c;
    end
  end

  assign timeout_err = tmo_q;
`else
  assign forced_c    = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // Next-state: arbitrate in IDLE, track address/data phases, release on burst end or stall.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    idx_d     = idx_q;
    rr_ptr_d  = rr_ptr_q;
    busy_d    = busy_q;
    release_c = 1'b0;
    unique case (state_q)
      ARB_IDLE: begin
        if (win_vld_c) begin
          state_d = ARB_ADDR;
          grant_d = SENDER_NUM'(1) << win_idx_c;
          idx_d   = win_idx_c;
          busy_d  = 1'b1;
        end
      end
      ARB_ADDR: begin
        if (addr_hs && last_hs) begin
          release_c = 1'b1;
        end else if (addr_hs) begin
          state_d = ARB_DATA;
        end
      end
      ARB_DATA: begin
        if (last_hs) release_c = 1'b1;
      end
      default: release_c = 1'b1;
    endcase
    if (forced_c) release_c = 1'b1;
    // Winner drops to lowest priority for the next arbitration.
    if (release_c) begin
      state_d  = ARB_IDLE;
      grant_d  = '0;
      idx_d    = '0;
      busy_d   = 1'b0;
      rr_ptr_d = idx_q;
    end
  end

  // State, grant and round-robin pointer registers.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q  <= ARB_IDLE;
      grant_q  <= '0;
      idx_q    <= '0;
      rr_ptr_q <= IDX_W'(SENDER_NUM - 1);
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      idx_q    <= idx_d;
      rr_ptr_q <= rr_ptr_d;
      busy_q   <= busy_d;
    end
  end

  assign grant     = grant_q;
  assign grant_idx = idx_q;
  assign busy      = busy_q;

endmodule
